// File: rtl/vid_timing_gen.sv
// Raster timing generator: divides clk into a pixel strobe, walks h/v counters and decodes
// sync/blank/de from a geometry shadow set that is reloaded only at enable and frame wrap.
module vid_timing_gen #(
    parameter int CW = 13,
    parameter int DW = 6
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          en,
    input  logic [DW-1:0] pcnt,
    input  logic [CW-1:0] hsize,
    input  logic [CW-1:0] hend,
    input  logic [CW-1:0] hsync_start,
    input  logic [CW-1:0] hsync_end,
    input  logic [CW-1:0] vsize,
    input  logic [CW-1:0] vend,
    input  logic [CW-1:0] vsync_start,
    input  logic [CW-1:0] vsync_end,
    input  logic          hsync_pol,
    input  logic          vsync_pol,
    output logic          pix_en,
    output logic [CW-1:0] hcount,
    output logic [CW-1:0] vcount,
    output logic          hsync,
    output logic          hblank,
    output logic          vsync,
    output logic          vblank,
    output logic          de,
    output logic          line_start,
    output logic          frame_start,
    output logic          cfg_err
);

    // Axis 0 is horizontal, axis 1 is vertical; both share the same decode structure.
    localparam int NAX = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    typedef struct packed {
        logic [CW-1:0] size;
        logic [CW-1:0] total;
        logic [CW-1:0] sync_start;
        logic [CW-1:0] sync_end;
        logic          pol;
    } axis_geom_t;

    typedef struct packed {
        logic [DW-1:0]        pcnt;
        axis_geom_t [NAX-1:0] ax;
    } geom_t;

    state_t                   state_reg, state_next;
    geom_t                    geom_in;
    geom_t                    geom_sh_reg, geom_sh_next;
    logic                     cfg_err_reg, cfg_err_next;
    logic [DW-1:0]            pdiv_reg, pdiv_next;
    logic [NAX-1:0][CW-1:0]   cnt_reg, cnt_next;
    logic                     pix_en_reg, pix_en_next;
    logic [NAX-1:0]           sync_reg, sync_next;
    logic [NAX-1:0]           blank_reg, blank_next;
    logic                     de_reg, de_next;
    logic                     line_start_reg, frame_start_reg;

    logic [NAX-1:0]           axis_ok;
    logic [NAX-1:0]           axis_last;
    logic [NAX-1:0]           sync_raw_next;
    logic                     cfg_ok;
    logic                     strobe;
    logic                     load;
    logic                     run_next;
    logic                     line_mark;
    logic                     frame_mark;

    always_comb begin
        geom_in                  = '0;
        geom_in.pcnt             = pcnt;
        geom_in.ax[0].size       = hsize;
        geom_in.ax[0].total      = hend;
        geom_in.ax[0].sync_start = hsync_start;
        geom_in.ax[0].sync_end   = hsync_end;
        geom_in.ax[0].pol        = hsync_pol;
        geom_in.ax[1].size       = vsize;
        geom_in.ax[1].total      = vend;
        geom_in.ax[1].sync_start = vsync_start;
        geom_in.ax[1].sync_end   = vsync_end;
        geom_in.ax[1].pol        = vsync_pol;
    end

    // Validity is judged on the incoming set because it only matters on the edge that loads it.
    genvar gi;
    generate
        for (gi = 0; gi < NAX; gi++) begin : g_axis
            assign axis_ok[gi]   = (geom_in.ax[gi].total != '0) &&
                                   (geom_in.ax[gi].size <= geom_in.ax[gi].total);
            assign axis_last[gi] = (cnt_reg[gi] == geom_sh_reg.ax[gi].total - CW'(1));

            assign blank_next[gi]    = !run_next || (cnt_next[gi] >= geom_sh_next.ax[gi].size);
            assign sync_raw_next[gi] = run_next &&
                                       (cnt_next[gi] >= geom_sh_next.ax[gi].sync_start) &&
                                       (cnt_next[gi] <  geom_sh_next.ax[gi].sync_end);
            assign sync_next[gi]     = sync_raw_next[gi] ^ geom_sh_next.ax[gi].pol;
        end
    endgenerate

    assign cfg_ok = &axis_ok;
    assign strobe = (pdiv_reg == geom_sh_reg.pcnt);

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        pdiv_next  = pdiv_reg;
        cnt_next   = cnt_reg;
        line_mark  = 1'b0;
        frame_mark = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (en) begin
                    load       = 1'b1;
                    state_next = cfg_ok ? ST_RUN : ST_ERR;
                    pdiv_next  = '0;
                    cnt_next   = '0;
                    line_mark  = cfg_ok;
                    frame_mark = cfg_ok;
                end
            end
            ST_RUN: begin
                if (!en) begin
                    state_next = ST_IDLE;
                    pdiv_next  = '0;
                    cnt_next   = '0;
                end else if (!strobe) begin
                    pdiv_next = pdiv_reg + DW'(1);
                end else begin
                    pdiv_next = '0;
                    if (!axis_last[0]) begin
                        cnt_next[0] = cnt_reg[0] + CW'(1);
                    end else begin
                        cnt_next[0] = '0;
                        line_mark   = 1'b1;
                        if (!axis_last[1]) begin
                            cnt_next[1] = cnt_reg[1] + CW'(1);
                        end else begin
                            // Frame wrap: pick up new geometry; a bad set parks the block in ERR.
                            cnt_next[1] = '0;
                            load        = 1'b1;
                            state_next  = cfg_ok ? ST_RUN : ST_ERR;
                            line_mark   = cfg_ok;
                            frame_mark  = cfg_ok;
                        end
                    end
                end
            end
            ST_ERR: begin
                if (!en) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                pdiv_next  = '0;
                cnt_next   = '0;
            end
        endcase
    end

    assign run_next     = (state_next == ST_RUN);
    assign geom_sh_next = load ? geom_in : geom_sh_reg;
    assign cfg_err_next = load ? !cfg_ok : cfg_err_reg;
    assign pix_en_next  = run_next && (pdiv_next == geom_sh_next.pcnt);
    assign de_next      = !blank_next[0] && !blank_next[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= ST_IDLE;
            geom_sh_reg     <= '0;
            cfg_err_reg     <= 1'b0;
            pdiv_reg        <= '0;
            cnt_reg         <= '0;
            pix_en_reg      <= 1'b0;
            sync_reg        <= '0;
            blank_reg       <= '1;
            de_reg          <= 1'b0;
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            geom_sh_reg     <= geom_sh_next;
            cfg_err_reg     <= cfg_err_next;
            pdiv_reg        <= pdiv_next;
            cnt_reg         <= cnt_next;
            pix_en_reg      <= pix_en_next;
            sync_reg        <= sync_next;
            blank_reg       <= blank_next;
            de_reg          <= de_next;
            line_start_reg  <= line_mark;
            frame_start_reg <= frame_mark;
        end
    end

    assign pix_en      = pix_en_reg;
    assign hcount      = cnt_reg[0];
    assign vcount      = cnt_reg[1];
    assign hsync       = sync_reg[0];
    assign vsync       = sync_reg[1];
    assign hblank      = blank_reg[0];
    assign vblank      = blank_reg[1];
    assign de          = de_reg;
    assign line_start  = line_start_reg;
    assign frame_start = frame_start_reg;
    assign cfg_err     = cfg_err_reg;

endmodule

// File: tb/tb_vid_timing_gen.sv
// Bench for vid_timing_gen: directed and random stimulus, every clock scored against a model
// that derives the raster position from the clock count since frame start.
module tb_vid_timing_gen;

    localparam int CW = 13;
    localparam int DW = 6;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          en;
    logic [DW-1:0] pcnt;
    logic [CW-1:0] hsize, hend, hsync_start, hsync_end;
    logic [CW-1:0] vsize, vend, vsync_start, vsync_end;
    logic          hsync_pol, vsync_pol;
    logic          pix_en;
    logic [CW-1:0] hcount, vcount;
    logic          hsync, hblank, vsync, vblank, de;
    logic          line_start, frame_start, cfg_err;

    always #5 clk = ~clk;

    vid_timing_gen #(.CW(CW), .DW(DW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .en          (en),
        .pcnt        (pcnt),
        .hsize       (hsize),
        .hend        (hend),
        .hsync_start (hsync_start),
        .hsync_end   (hsync_end),
        .vsize       (vsize),
        .vend        (vend),
        .vsync_start (vsync_start),
        .vsync_end   (vsync_end),
        .hsync_pol   (hsync_pol),
        .vsync_pol   (vsync_pol),
        .pix_en      (pix_en),
        .hcount      (hcount),
        .vcount      (vcount),
        .hsync       (hsync),
        .hblank      (hblank),
        .vsync       (vsync),
        .vblank      (vblank),
        .de          (de),
        .line_start  (line_start),
        .frame_start (frame_start),
        .cfg_err     (cfg_err)
    );

    typedef struct packed {
        logic          pix_en;
        logic [CW-1:0] hcount;
        logic [CW-1:0] vcount;
        logic          hsync;
        logic          hblank;
        logic          vsync;
        logic          vblank;
        logic          de;
        logic          line_start;
        logic          frame_start;
        logic          cfg_err;
    } out_t;

    typedef struct {
        int pcnt;
        int hsize;
        int hend;
        int hss;
        int hse;
        int vsize;
        int vend;
        int vss;
        int vse;
        bit hpol;
        bit vpol;
    } geom_t;

    typedef enum int { M_IDLE, M_RUN, M_ERR } mode_t;

    mode_t  m_mode;
    geom_t  m_sh;
    bit     m_cfg_err;
    longint m_t;

    out_t  exp_q[$];
    string tag_q[$];
    int    tests   = 0;
    int    fails   = 0;
    int    cyc_cnt = 0;
    string phase   = "reset";

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic geom_t sample_geom();
        geom_t g;
        g.pcnt  = int'(pcnt);
        g.hsize = int'(hsize);
        g.hend  = int'(hend);
        g.hss   = int'(hsync_start);
        g.hse   = int'(hsync_end);
        g.vsize = int'(vsize);
        g.vend  = int'(vend);
        g.vss   = int'(vsync_start);
        g.vse   = int'(vsync_end);
        g.hpol  = hsync_pol;
        g.vpol  = vsync_pol;
        return g;
    endfunction

    function automatic bit geom_ok(input geom_t g);
        return (g.hend != 0) && (g.vend != 0) && (g.hsize <= g.hend) && (g.vsize <= g.vend);
    endfunction

    function automatic void model_reset();
        m_mode    = M_IDLE;
        m_sh      = '{default: 0};
        m_cfg_err = 1'b0;
        m_t       = 0;
    endfunction

    function automatic void model_load();
        m_sh      = sample_geom();
        m_cfg_err = !geom_ok(m_sh);
        m_mode    = m_cfg_err ? M_ERR : M_RUN;
        m_t       = 0;
    endfunction

    // One active clock edge of the reference: time advances, frames restart every frame_len clocks.
    function automatic void model_step();
        longint frame_len;
        if (!reset_n) begin
            model_reset();
        end else if (!en) begin
            m_mode = M_IDLE;
        end else if (m_mode == M_IDLE) begin
            model_load();
        end else if (m_mode == M_RUN) begin
            frame_len = longint'(m_sh.pcnt + 1) * longint'(m_sh.hend) * longint'(m_sh.vend);
            m_t++;
            if (m_t == frame_len) model_load();
        end
    endfunction

    function automatic out_t model_out();
        out_t   o;
        longint d, pix;
        int     h, v;
        o         = '0;
        o.cfg_err = m_cfg_err;
        if (m_mode == M_RUN) begin
            d             = longint'(m_sh.pcnt) + 1;
            pix           = m_t / d;
            h             = int'(pix % longint'(m_sh.hend));
            v             = int'(pix / longint'(m_sh.hend));
            o.pix_en      = ((m_t % d) == d - 1);
            o.hcount      = CW'(h);
            o.vcount      = CW'(v);
            o.hblank      = (h >= m_sh.hsize);
            o.vblank      = (v >= m_sh.vsize);
            o.hsync       = ((h >= m_sh.hss) && (h < m_sh.hse)) ^ m_sh.hpol;
            o.vsync       = ((v >= m_sh.vss) && (v < m_sh.vse)) ^ m_sh.vpol;
            o.de          = !o.hblank && !o.vblank;
            o.line_start  = ((m_t % (d * longint'(m_sh.hend))) == 0);
            o.frame_start = (m_t == 0);
        end else begin
            o.hblank = 1'b1;
            o.vblank = 1'b1;
            o.hsync  = m_sh.hpol;
            o.vsync  = m_sh.vpol;
        end
        return o;
    endfunction

    function automatic string fmt(input out_t o);
        return $sformatf("pe=%b h=%0d v=%0d hs=%b hb=%b vs=%b vb=%b de=%b ls=%b fs=%b err=%b",
                         o.pix_en, o.hcount, o.vcount, o.hsync, o.hblank, o.vsync, o.vblank,
                         o.de, o.line_start, o.frame_start, o.cfg_err);
    endfunction

    // Each edge: advance the reference and queue what the DUT must show after that edge.
    task automatic cycle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            exp_q.push_back(model_out());
            tag_q.push_back(phase);
            #1;
        end
    endtask

    task automatic set_geom(input int pc, input int hs, input int he, input int hss, input int hse,
                            input int vs, input int ve, input int vss, input int vse,
                            input bit hp, input bit vp);
        pcnt        = DW'(pc);
        hsize       = CW'(hs);
        hend        = CW'(he);
        hsync_start = CW'(hss);
        hsync_end   = CW'(hse);
        vsize       = CW'(vs);
        vend        = CW'(ve);
        vsync_start = CW'(vss);
        vsync_end   = CW'(vse);
        hsync_pol   = hp;
        vsync_pol   = vp;
    endtask

    task automatic rand_geom();
        int he, ve;
        he = int'($urandom_range(0, 9));
        ve = int'($urandom_range(0, 5));
        set_geom(int'($urandom_range(0, 3)), int'($urandom_range(0, he + 1)), he,
                 int'($urandom_range(0, 10)), int'($urandom_range(0, 10)),
                 int'($urandom_range(0, ve + 1)), ve,
                 int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    task automatic note();
        $display("[TB] scenario %s done at cycle %0d", phase, cyc_cnt);
    endtask

    // Monitor: compares the full output bundle once per clock, away from the active edge.
    initial begin
        out_t  e, a;
        string tg;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e             = exp_q.pop_front();
                tg            = tag_q.pop_front();
                a.pix_en      = pix_en;
                a.hcount      = hcount;
                a.vcount      = vcount;
                a.hsync       = hsync;
                a.hblank      = hblank;
                a.vsync       = vsync;
                a.vblank      = vblank;
                a.de          = de;
                a.line_start  = line_start;
                a.frame_start = frame_start;
                a.cfg_err     = cfg_err;
                tests++;
                if (a !== e) begin
                    fails++;
                    $display("FAIL %s cycle %0d: got %s, want %s", tg, cyc_cnt, fmt(a), fmt(e));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        en      = 1'b0;
        set_geom(0, 4, 8, 5, 6, 2, 4, 3, 4, 1'b0, 1'b0);
        model_reset();

        phase = "reset";
        cycle(4);
        reset_n = 1'b1;
        cycle(4);
        note();

        phase = "basic";
        en = 1'b1;
        cycle(70);
        en = 1'b0;
        cycle(2);
        note();

        phase = "divider";
        set_geom(2, 4, 8, 5, 6, 2, 4, 3, 4, 1'b0, 1'b0);
        en = 1'b1;
        cycle(200);
        en = 1'b0;
        cycle(2);
        note();

        phase = "polarity";
        set_geom(0, 4, 8, 5, 6, 2, 4, 3, 4, 1'b1, 1'b1);
        en = 1'b1;
        cycle(40);
        en = 1'b0;
        cycle(4);
        note();

        phase = "reprogram";
        set_geom(0, 4, 8, 5, 6, 2, 4, 3, 4, 1'b0, 1'b0);
        en = 1'b1;
        cycle(10);
        hsize = CW'(6);
        cycle(70);
        note();

        // Asynchronous reset mid-run: the entry queued for the last edge is superseded by reset.
        phase   = "async_reset";
        reset_n = 1'b0;
        en      = 1'b0;
        model_reset();
        exp_q[exp_q.size() - 1] = model_out();
        cycle(3);
        reset_n = 1'b1;
        cycle(5);
        note();

        phase = "invalid";
        set_geom(0, 4, 0, 5, 6, 2, 4, 3, 4, 1'b0, 1'b0);
        en = 1'b1;
        cycle(6);
        hend = CW'(8);
        cycle(6);
        en = 1'b0;
        cycle(1);
        en = 1'b1;
        cycle(40);
        en = 1'b0;
        cycle(2);
        note();

        phase = "random";
        for (int r = 0; r < 16; r++) begin
            int n;
            rand_geom();
            n = int'($urandom_range(60, 400));
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 99) < 3) rand_geom();
                en = ($urandom_range(0, 99) != 0);
                cycle(1);
            end
            en = 1'b0;
            cycle(2);
        end
        note();

        @(negedge clk);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations pending, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
